// File: rtl/dm_wait_responder.sv
// dm_wait_responder: data-memory responder that answers each MEM-stage access after WAIT_CYCLES wait states
module dm_wait_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_err,
  output logic        dm_stall
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t          r_state, w_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_wr, r_err;
  logic [31:0]     r_mem [DEPTH];
  logic            w_req, w_err, w_commit;
  assign w_req    = dm_read | dm_write;
  assign w_err    = (|dm_addr[1:0]) | (|dm_addr[31:AW+2]) | (dm_read & dm_write);
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd0);
  always_comb begin
    w_next   = r_state;
    dm_stall = 1'b0;
    dm_valid = 1'b0;
    dm_err   = 1'b0;
    case (r_state)
      IDLE: begin
        dm_stall = w_req;
        w_next   = w_req ? BUSY : IDLE;
      end
      BUSY: begin
        dm_stall = 1'b1;
        w_next   = (r_cnt == 4'd0) ? RESP : BUSY;
      end
      RESP: begin
        dm_valid = 1'b1;
        dm_err   = r_err;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_idx    <= '0;
      r_wdata  <= 32'd0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      dm_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_idx   <= dm_addr[AW+1:2];
        r_wdata <= dm_wdata;
        r_wr    <= dm_write;
        r_err   <= w_err;
        r_cnt   <= 4'(WAIT_CYCLES);
      end
      if (r_state == BUSY && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_commit && (r_err || !r_wr))
        dm_rdata <= r_err ? 32'd0 : r_mem[r_idx];
    end
  end
  // array is never cleared; reset on the commit edge suppresses the write
  always_ff @(posedge clk)
    if (!rst && w_commit && r_wr && !r_err)
      r_mem[r_idx] <= r_wdata;
endmodule

// File: tb/tb_dm_wait_responder.sv
// tb_dm_wait_responder: randomized check of two responder instances (2 and 0 wait states) against an array model
module tb_dm_wait_responder;
  localparam int D = 32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd = 2'b00, wr = 2'b00;
  logic [1:0]  valid, err, stall;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [31:0] m [2][D];
  logic [31:0] er [2];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dm_wait_responder #(.DEPTH(D), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .dm_read(rd[0]), .dm_write(wr[0]), .dm_addr(addr[0]),
    .dm_wdata(wdata[0]), .dm_rdata(rdata[0]), .dm_valid(valid[0]), .dm_err(err[0]), .dm_stall(stall[0]));
  dm_wait_responder #(.DEPTH(D), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .dm_read(rd[1]), .dm_write(wr[1]), .dm_addr(addr[1]),
    .dm_wdata(wdata[1]), .dm_rdata(rdata[1]), .dm_valid(valid[1]), .dm_err(err[1]), .dm_stall(stall[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic int wc(input int s);
    return (s == 0) ? 2 : 0;
  endfunction
  // one complete access; inputs held through RESP, garbage driven while busy
  task automatic access(input int s, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    int  n   = wc(s);
    int  idx = int'((a >> 2) % D);
    bit  e   = (a[1:0] != 2'b00) || (a >= 4 * D) || (r && w);
    if (e) er[s] = 32'd0;
    else if (r) er[s] = m[s][idx];
    else m[s][idx] = d;
    rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
    for (int c = 0; c <= n + 2; c++) begin
      @(negedge clk);
      chk("stall", 32'(stall[s]), 32'(c <= n + 1));
      chk("valid", 32'(valid[s]), 32'(c == n + 2));
      if (c == n + 2) begin
        chk("err", 32'(err[s]), 32'(e));
        chk("rdata", rdata[s], er[s]);
      end
      @(posedge clk); #1;
      if (c + 1 <= n + 1) begin
        rd[s] = 1'($urandom); wr[s] = 1'($urandom); addr[s] = $urandom; wdata[s] = $urandom;
      end else begin
        rd[s] = r; wr[s] = w; addr[s] = a; wdata[s] = d;
      end
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask
  // write abandoned by reset seen at the edge ending cycle k (k = n+1 is the commit edge)
  task automatic abort_wr(input int s, input logic [31:0] a, input logic [31:0] d, input int k);
    rd[s] = 1'b0; wr[s] = 1'b1; addr[s] = a; wdata[s] = d;
    for (int c = 0; c < k; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; wr[s] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; er[0] = 32'd0; er[1] = 32'd0;
    @(negedge clk);
    chk("rst_stall", 32'(stall[s]), 32'd0);
    chk("rst_valid", 32'(valid[s]), 32'd0);
    chk("rst_rdata", rdata[s], 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    int s, sel;
    bit r, w;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'd0; wdata[i] = 32'd0; er[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rdata", rdata[i], 32'd0);
      chk("reset_valid", 32'(valid[i]), 32'd0);
      chk("reset_err", 32'(err[i]), 32'd0);
      chk("reset_stall", 32'(stall[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < D; j++) access(i, 1'b0, 1'b1, 32'(j * 4), $urandom);
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0);
    access(0, 1'b1, 1'b0, 32'h13, 32'd0);
    access(0, 1'b1, 1'b0, 32'(4 * D), 32'd0);
    access(0, 1'b0, 1'b1, 32'h11, 32'hBAD0BAD0);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0);
    access(0, 1'b1, 1'b1, 32'h20, 32'h5);
    access(0, 1'b1, 1'b0, 32'h20, 32'd0);
    abort_wr(0, 32'h40, 32'h1234, 1);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0);
    abort_wr(0, 32'h40, 32'h1234, 3);
    access(0, 1'b1, 1'b0, 32'h40, 32'd0);
    abort_wr(1, 32'h44, 32'h5678, 1);
    access(1, 1'b1, 1'b0, 32'h44, 32'd0);
    access(1, 1'b1, 1'b0, 32'h0, 32'd0);
    access(1, 1'b1, 1'b0, 32'h4, 32'd0);
    access(1, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'h8, 32'd0);
    repeat (250) begin
      s   = $urandom_range(0, 1);
      sel = $urandom_range(0, 19);
      r   = sel < 9;
      w   = (sel >= 9 && sel < 18) || sel == 19;
      r   = r || sel == 19;
      if (sel == 18) begin
        r = 1'b1; w = 1'b0;
      end
      a = {25'd0, 5'($urandom_range(0, D - 1)), 2'b00};
      case ($urandom_range(0, 9))
        0: a[1:0] = 2'($urandom_range(1, 3));
        1: a = 32'($urandom_range(4 * D, 4 * D + 64));
        2: a = $urandom | 32'h8000_0000;
        default: ;
      endcase
      access(s, r, w, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
